// File: rtl/tt_um_neural_network.sv
// Purpose : 4-2-1 signed 8-bit MLP (ReLU hidden layer) with a byte-wide register write port.
// Latency : result on uo_out and done=1 on the 10th rising edge after the edge that accepts start.
// Backpr. : none; writes and start edges that arrive while an inference is running are dropped.
//
// Ports:
//   clk, rst_n      - single rising-edge clock, asynchronous active-low reset
//   ena             - design select, no functional effect
//   ui_in[7:0]      - write data byte (signed)
//   uio_in[7:0]     - [0]=wr_en, [5:1]=addr, [6]=start, [7] unused
//   uo_out[7:0]     - last inference result y (signed)
//   uio_out[7:0]    - [7]=done, others 0
//   uio_oe[7:0]     - constant 8'h80 (only the done pin is driven)
module tt_um_neural_network (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {ST_IDLE, ST_HID0, ST_HID1, ST_OUT} state_t;

  localparam logic signed [19:0] H_MAX = 20'sd127;
  localparam logic signed [19:0] Y_MAX = 20'sd127;
  localparam logic signed [19:0] Y_MIN = -20'sd128;

  // Register file: 0-3 x, 4-11 W[j][i] at 4+4j+i, 12-13 bh, 14-15 v, 16 bo.
  logic [7:0]  regs_q [0:16];
  logic [7:0]  regs_d [0:16];
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [6:0]  h0_q, h0_d;
  logic [6:0]  h1_q, h1_d;
  logic [7:0]  y_q, y_d;
  logic        done_q, done_d;
  logic        start_prev_q, start_prev_d;

  logic        wr_en;
  logic [4:0]  addr;
  logic        start;
  logic        start_edge;
  logic        unused_ok;

  assign wr_en      = uio_in[0];
  assign addr       = uio_in[5:1];
  assign start      = uio_in[6];
  assign start_edge = start & ~start_prev_q;
  assign unused_ok  = &{1'b0, ena, uio_in[7]};

  // Bias placed in the accumulator's Q.6 format: sign-extend, then << 6.
  function automatic logic [19:0] bias_init(input logic [7:0] b);
    return {{6{b[7]}}, b, 6'b000000};
  endfunction

  // MAC operands. op_b is 9 bits so an unsigned hidden value (0..127) and a
  // signed input byte share one signed multiplier.
  logic [7:0]         op_a;
  logic [8:0]         op_b;
  logic [7:0]         x_sel;
  logic [16:0]        prod;
  logic [19:0]        acc_sum;
  logic signed [19:0] acc_shr;
  logic [6:0]         h_sat;
  logic [7:0]         y_sat;

  always_comb begin
    op_a  = 8'h00;
    op_b  = 9'h000;
    x_sel = regs_q[{3'b000, cnt_q}];
    case (state_q)
      ST_HID0: begin
        op_a = regs_q[{3'b001, cnt_q}];
        op_b = {x_sel[7], x_sel};
      end
      ST_HID1: begin
        op_a = regs_q[{3'b010, cnt_q}];
        op_b = {x_sel[7], x_sel};
      end
      ST_OUT: begin
        op_a = regs_q[{4'b0111, cnt_q[0]}];
        op_b = {2'b00, (cnt_q[0] ? h1_q : h0_q)};
      end
      default: ;
    endcase
  end

  // Both operands sign-extended to 17 bits; the true product always fits,
  // so the truncated two's-complement product is exact.
  assign prod    = {{9{op_a[7]}}, op_a} * {{8{op_b[8]}}, op_b};
  assign acc_sum = acc_q + {{3{prod[16]}}, prod};
  assign acc_shr = $signed(acc_sum) >>> 6;

  always_comb begin
    if (acc_shr[19])
      h_sat = 7'd0;
    else if (acc_shr > H_MAX)
      h_sat = 7'd127;
    else
      h_sat = acc_shr[6:0];

    if (acc_shr < Y_MIN)
      y_sat = 8'h80;
    else if (acc_shr > Y_MAX)
      y_sat = 8'h7F;
    else
      y_sat = acc_shr[7:0];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    h0_d         = h0_q;
    h1_d         = h1_q;
    y_d          = y_q;
    done_d       = done_q;
    regs_d       = regs_q;
    start_prev_d = start;

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          if (addr <= 5'd16) regs_d[addr] = ui_in;
          done_d = 1'b0;
        end else if (start_edge) begin
          state_d = ST_HID0;
          cnt_d   = 2'd0;
          acc_d   = bias_init(regs_q[12]);
          done_d  = 1'b0;
        end
      end
      ST_HID0: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          h0_d    = h_sat;
          state_d = ST_HID1;
          cnt_d   = 2'd0;
          acc_d   = bias_init(regs_q[13]);
        end
      end
      ST_HID1: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          h1_d    = h_sat;
          state_d = ST_OUT;
          cnt_d   = 2'd0;
          acc_d   = bias_init(regs_q[16]);
        end
      end
      ST_OUT: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          y_d     = y_sat;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      acc_q        <= 20'd0;
      h0_q         <= 7'd0;
      h1_q         <= 7'd0;
      y_q          <= 8'd0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
      for (int i = 0; i < 17; i++) regs_q[i] <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      h0_q         <= h0_d;
      h1_q         <= h1_d;
      y_q          <= y_d;
      done_q       <= done_d;
      start_prev_q <= start_prev_d;
      for (int i = 0; i < 17; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign uo_out  = y_q;
  assign uio_out = {done_q, 7'b0000000};
  assign uio_oe  = 8'h80;

endmodule

// File: tb/tb_tt_um_neural_network.sv
module tb_tt_um_neural_network;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_neural_network dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    ui_in  = d;
    uio_in = {2'b00, a, 1'b1};
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  // Start one inference and check timing of done and the result.
  task automatic run_chk(input string tag, input logic [7:0] prev, input logic [7:0] exp);
    @(negedge clk);
    uio_in = 8'h40;
    @(negedge clk);                 // edge 0 (acceptance) has passed
    uio_in = 8'h00;
    chk({tag, "_accept_done"}, uio_out, 8'h00);
    repeat (9) @(negedge clk);      // edges 1..9
    chk({tag, "_early_done"}, uio_out, 8'h00);
    chk({tag, "_early_y"}, uo_out, prev);
    @(negedge clk);                 // edge 10
    chk({tag, "_y"}, uo_out, exp);
    chk({tag, "_done"}, uio_out, 8'h80);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #2;
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h80);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero parameters.
    run_chk("zero", 8'h00, 8'h00);

    // Write clears done; output bias only.
    wr(5'd16, 8'd5);
    chk("wr_clears_done", uio_out, 8'h00);
    chk("wr_keeps_y", uo_out, 8'h00);
    run_chk("bias", 8'h00, 8'h05);

    // Linear path: 64*64>>6 = 64 -> h0=64, y=64; with bo=-3 -> 61.
    do_reset();
    wr(5'd0, 8'd64);
    wr(5'd4, 8'd64);
    wr(5'd14, 8'd64);
    run_chk("lin", 8'h00, 8'h40);
    wr(5'd16, 8'hFD);
    run_chk("lin_bo", 8'h40, 8'h3D);
    run_chk("lin_repeat", 8'h3D, 8'h3D);

    // ReLU: W00=-64 -> h0=0, y=bo=-3.
    wr(5'd4, 8'hC0);
    run_chk("relu", 8'h3D, 8'hFD);

    // Saturation: 127*127>>6 = 252 -> h0=127, y=252 -> 127; v0=-128 -> -254 -> -128.
    do_reset();
    wr(5'd0, 8'd127);
    wr(5'd4, 8'd127);
    wr(5'd14, 8'd127);
    run_chk("sat_pos", 8'h00, 8'h7F);
    wr(5'd14, 8'h80);
    run_chk("sat_neg", 8'h7F, 8'h80);

    // Busy: write x0=0 and a fresh start edge during HID1 are both dropped.
    @(negedge clk);
    uio_in = 8'h40;
    @(negedge clk);                 // edge 0
    uio_in = 8'h00;
    repeat (5) @(negedge clk);      // edges 1..5
    ui_in  = 8'h00;
    uio_in = {2'b00, 5'd0, 1'b1};
    @(negedge clk);                 // edge 6: write while busy
    uio_in = 8'h40;
    @(negedge clk);                 // edge 7: start edge while busy
    uio_in = 8'h00;
    repeat (2) @(negedge clk);      // edges 8, 9
    chk("busy_early_done", uio_out, 8'h00);
    @(negedge clk);                 // edge 10
    chk("busy_y", uo_out, 8'h80);
    chk("busy_done", uio_out, 8'h80);
    repeat (12) @(negedge clk);
    chk("busy_done_held", uio_out, 8'h80);
    run_chk("busy_rerun", 8'h80, 8'h80);

    // Second hidden neuron with x3/W[1][3]: (64+200)>>6 = 4 -> h1=4; 100*4>>6 = 6.
    do_reset();
    wr(5'd3, 8'd10);
    wr(5'd11, 8'd20);
    wr(5'd13, 8'd1);
    wr(5'd15, 8'd100);
    run_chk("h1", 8'h00, 8'h06);

    // Abort mid-inference with reset.
    @(negedge clk);
    uio_in = 8'h40;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_uo_out", uo_out, 8'h00);
    chk("abort_done", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk("post_abort", 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_neural_network.md
TT_UM_NEURAL_NETWORK -- requirements
Module: tt_um_neural_network

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: ena  in  1  design-select; ignored, no functional effect.
REQ-004 SHALL have ports: ui_in  in  8  write data byte (signed two's complement).
REQ-005 SHALL have ports: uio_in  in  8  control: [0]=wr_en, [5:1]=addr, [6]=start, [7] unused.
REQ-006 SHALL have ports: uo_out  out  8  last inference result y (signed).
REQ-007 SHALL have ports: uio_out  out  8  [7]=done, [6:0]=0.
REQ-008 SHALL have ports: uio_oe  out  8  constant 8'h80.
REQ-009 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-010 SHALL implement a 4-2-1 network: inputs x0..x3, hidden h0,h1 with ReLU, output y; all parameters signed 8-bit.
REQ-011 SHALL map register addresses: 0-3 x0..x3; 4+4j+i W[j][i] (j=0..1, i=0..3); 12-13 bh0,bh1; 14-15 v0,v1; 16 bo; 17-31 writes ignored.
REQ-012 SHALL write ui_in to addr on a rising clk edge when wr_en=1 and state is IDLE; writes while busy are ignored.
REQ-013 SHALL detect start as a rising edge (start=1 this cycle, 0 in the previous sampled cycle); a start edge is accepted only in IDLE and only when wr_en=0; otherwise it is dropped.
REQ-014 SHALL use states IDLE -> HID0 (4 cycles) -> HID1 (4 cycles) -> OUT (2 cycles) -> IDLE, with one MAC per cycle.
REQ-015 SHALL initialize a 20-bit signed accumulator to (bias sign-extended) << 6 on entering each layer: bh0 for HID0, bh1 for HID1, bo for OUT.
REQ-016 SHALL add the full-precision 16-bit signed product W[j][i]*x_i in cycle i of HIDj, and v_k*h_k in cycle k of OUT.
REQ-017 SHALL compute h_j = clamp(acc >>> 6, 0, 127) after the last HIDj MAC, using floor arithmetic shift with ReLU and saturation; h_j is used as an unsigned value 0..127.
REQ-018 SHALL compute y = clamp(acc >>> 6, -128, 127) after the last OUT MAC.
REQ-019 SHALL register y to uo_out and set done=1 on the 10th rising edge after the edge that accepted start; uo_out SHALL hold its value otherwise.
REQ-020 SHALL clear done on the edge that accepts a new start or performs a write; done SHALL otherwise stay high.
REQ-021 SHALL leave parameters untouched by an inference, so repeated starts give identical y.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force state=IDLE, all parameter registers=0, accumulator=0, h0=h1=0, uo_out=0, done=0, and the start edge detector's previous value=0.
REQ-023 SHALL abort any in-flight inference on reset; the first start edge after rst_n rises SHALL be accepted normally.

Verification
REQ-024 Reset: rst_n=0 -> uo_out=0x00, uio_out=0x00, uio_oe=0x80; after release, start with all-zero params -> y=0x00, done=1 after 10 clocks.
REQ-025 Bias path: write bo=5 only, then start -> uo_out=0x05 and uio_out[7]=1 exactly 10 edges after acceptance, not earlier.
REQ-026 Linear path: x0=64, W[0][0]=64, v0=64, rest 0 -> h0=64, uo_out=0x40; with bo=-3 additionally -> 0x3D.
REQ-027 ReLU and negative output: x0=64, W[0][0]=-64, v0=64, bo=-3 -> h0=0, uo_out=0xFD.
REQ-028 Saturation: x0=127, W[0][0]=127, v0=127 -> h0 clamps to 127, uo_out=0x7F; with v0=-128 -> uo_out=0x80.
REQ-029 Busy and abort: a write to x0 and a second start edge issued during HID1 are both ignored (result unchanged); asserting rst_n=0 mid-inference leaves done=0 and uo_out=0.
